apb_master_bridge: RTL and testbench

Upstream APB requester that drives the register slave. Converts a simple valid/ready request/response interface into compliant two-phase APB transfers (SETUP → ACCESS), one transfer at a time. Returns read data and slave error to the requester. A wait-state watchdog aborts transfers whose PREADY never arrives.

---
 rtl/apb_master_bridge_pkg.sv | 26 ++
 rtl/apb_master_bridge_if.sv | 54 +++++
 rtl/apb_master_bridge.sv | 113 +++++++++++
 tb/tb_apb_master_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared APB requester types: state encoding, default bus widths and the response record.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    // Sized to the default data width; wider buses would need a wider record.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;

    // Width of the wait-state counter: enough to hold the limit, never zero bits.
    function automatic int wait_cnt_w(input int timeout);
        return (timeout <= 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response handshake plus APB bus of the requester bridge, bundled as one interface.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;

    logic              busy;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    // Bridge side.
    modport master (
        input  req_valid, req_addr, req_write, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output busy,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    // Requester plus APB completer side.
    modport slave (
        output req_valid, req_addr, req_write, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: turns one accepted request into a SETUP->ACCESS transfer and returns data/error/timeout.
// Latency: accept at edge N, completion at N+2+wait states; one transfer in flight, 4 cycles minimum each.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready, which stalls new requests.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETUP  = SETUP;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_RESP   = RESP;

    localparam int             CNT_W     = wait_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit             WDOG_EN   = (TIMEOUT_CYCLES != 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    apb_rsp_t         rsp_q;

    assign bus.rsp_rdata   = DATA_W'(rsp_q.rdata);
    assign bus.rsp_slverr  = rsp_q.slverr;
    assign bus.rsp_timeout = rsp_q.timeout;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            rsp_q         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        bus.PADDR     <= bus.req_addr;
                        bus.PWRITE    <= bus.req_write;
                        bus.PWDATA    <= bus.req_write ? bus.req_wdata : '0;
                        bus.PSEL      <= 1'b1;
                        bus.PENABLE   <= 1'b0;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= S_ACCESS;
                end

                S_ACCESS: begin
                    // A ready slave beats the watchdog on the cycle the limit is reached.
                    if (bus.PREADY) begin
                        rsp_q <= '{rdata:   bus.PWRITE ? '0 : APB_DATA_W'(bus.PRDATA),
                                   slverr:  bus.PSLVERR,
                                   timeout: 1'b0};
                        bus.rsp_valid <= 1'b1;
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.PWRITE    <= 1'b0;
                        bus.PADDR     <= '0;
                        bus.PWDATA    <= '0;
                        state         <= S_RESP;
                    end else if (WDOG_EN && wait_cnt == CNT_LIMIT) begin
                        rsp_q <= '{rdata: '0, slverr: 1'b1, timeout: 1'b1};
                        bus.rsp_valid <= 1'b1;
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.PWRITE    <= 1'b0;
                        bus.PADDR     <= '0;
                        bus.PWDATA    <= '0;
                        state         <= S_RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= S_IDLE;
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: register-slave model with wait states/hang, vector table, directed corners, random traffic.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus.master)
    );

    int errors = 0;
    int checks = 0;

    // Register slave: 64 words below 0x100, error above; programmable wait states or never ready.
    logic [31:0] smem [64] = '{default: 32'h0};
    int slv_waits = 0;
    bit slv_hang  = 1'b0;
    int slv_cnt   = 0;

    always @(negedge clk) begin
        if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1 && !slv_hang && slv_cnt >= slv_waits) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = (bus.PADDR >= 32'h100);
            if (bus.PSLVERR) begin
                bus.PRDATA = 32'h0;
            end else if (bus.PWRITE) begin
                smem[bus.PADDR[7:2]] = bus.PWDATA;
                bus.PRDATA = $urandom;
            end else begin
                bus.PRDATA = smem[bus.PADDR[7:2]];
            end
            slv_cnt = 0;
        end else begin
            // Garbage outside the completing edge must be ignored by the bridge.
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'($urandom);
            bus.PRDATA  = $urandom;
            slv_cnt = (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) ? slv_cnt + 1 : 0;
        end
    end

    // Reference model: word memory plus the outcome rules of a transfer.
    logic [31:0] mmem [64] = '{default: 32'h0};

    task automatic predict(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input bit hang, output logic [31:0] r, output logic e, output logic t);
        r = 32'h0;
        e = 1'b0;
        t = 1'b0;
        if (hang) begin
            e = 1'b1;
            t = 1'b1;
        end else if (addr >= 32'h100) begin
            e = 1'b1;
        end else if (wr) begin
            mmem[addr[7:2]] = wdata;
        end else begin
            r = mmem[addr[7:2]];
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wdata;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 64'(n < 100), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_write = 1'($urandom);
        bus.req_wdata = $urandom;
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic get_rsp(input string name, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [31:0] e_rdata,
                           input logic e_err, input logic e_to, input int e_lat);
        int lat;
        int pen;
        bit stable;
        logic [31:0] pw;
        lat = 0;
        pen = 0;
        stable = 1'b1;
        pw = wr ? wdata : 32'h0;
        chk({name, ".setup"}, {bus.PSEL, bus.PENABLE, bus.PWRITE}, {2'b10, wr});
        chk({name, ".paddr"}, bus.PADDR, addr);
        chk({name, ".pwdata"}, bus.PWDATA, pw);
        while (bus.rsp_valid !== 1'b1 && lat < 200) begin
            if (bus.PSEL !== 1'b1 || bus.PADDR !== addr || bus.PWDATA !== pw || bus.PWRITE !== wr)
                stable = 1'b0;
            if (bus.PENABLE === 1'b1) pen++;
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, lat, e_lat);
        chk({name, ".penable_cycles"}, pen, e_lat - 1);
        chk({name, ".bus_stable"}, stable, 1'b1);
        chk({name, ".rdata"}, bus.rsp_rdata, e_rdata);
        chk({name, ".slverr_timeout"}, {bus.rsp_slverr, bus.rsp_timeout}, {e_err, e_to});
        chk({name, ".bus_idle"}, {bus.PSEL, bus.PENABLE, bus.PWRITE, |bus.PADDR, |bus.PWDATA}, 5'b0);
        chk({name, ".busy_rdy"}, {bus.busy, bus.req_ready}, 2'b10);
    endtask

    task automatic ack_rsp(input string name);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({name, ".after_ack"}, {bus.rsp_valid, bus.busy, bus.req_ready}, 3'b001);
    endtask

    task automatic run_xfer(input string name, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wdata, input int waits, input bit hang,
                            input logic [31:0] e_rdata, input logic e_err, input logic e_to,
                            input int e_lat);
        slv_waits = waits;
        slv_hang  = hang;
        send_req(addr, wr, wdata);
        get_rsp(name, addr, wr, wdata, e_rdata, e_err, e_to, e_lat);
        ack_rsp(name);
        slv_hang  = 1'b0;
        slv_waits = 0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        bit          hang;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] a, d, r, held_rdata;
        logic w, e, t, held_err, held_to;
        int ws;
        bit h;

        vecs[0] = '{32'h14,  1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0, 1'b0, 2};
        vecs[1] = '{32'h14,  1'b0, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 2};
        vecs[2] = '{32'h100, 1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b1, 1'b0, 2};
        vecs[3] = '{32'h14,  1'b0, 32'h0,        3, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 5};
        vecs[4] = '{32'h20,  1'b0, 32'h0,        0, 1'b1, 32'h0,        1'b1, 1'b1, 2 + TMO};
        vecs[5] = '{32'h20,  1'b1, 32'hCAFEF00D, 0, 1'b0, 32'h0,        1'b0, 1'b0, 2};
        vecs[6] = '{32'h20,  1'b0, 32'h0,        1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 3};
        vecs[7] = '{32'h104, 1'b1, 32'h1,        2, 1'b0, 32'h0,        1'b1, 1'b0, 4};

        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_write = 1'b0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.apb", {bus.PSEL, bus.PENABLE, bus.PWRITE, |bus.PADDR, |bus.PWDATA}, 5'b0);
        chk("reset.rsp", {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, |bus.rsp_rdata}, 4'b0);
        chk("reset.state", {bus.busy, bus.req_ready}, 2'b01);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            predict(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].hang, r, e, t);
            run_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wdata,
                     vecs[i].waits, vecs[i].hang, vecs[i].e_rdata, vecs[i].e_err,
                     vecs[i].e_to, vecs[i].e_lat);
        end

        // Response held off for 5 cycles while a second request waits.
        predict(32'h40, 1'b1, 32'hA5A5A5A5, 1'b0, r, e, t);
        send_req(32'h40, 1'b1, 32'hA5A5A5A5);
        get_rsp("hold_wr", 32'h40, 1'b1, 32'hA5A5A5A5, r, e, t, 2);
        held_rdata = bus.rsp_rdata;
        held_err   = bus.rsp_slverr;
        held_to    = bus.rsp_timeout;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h40;
        bus.req_write = 1'b0;
        bus.req_wdata = 32'h77;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold.payload%0d", k),
                {bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout},
                {1'b1, held_rdata, held_err, held_to});
            chk($sformatf("hold.stalled%0d", k), {bus.req_ready, bus.PSEL}, 2'b00);
        end
        ack_rsp("hold_wr");
        predict(32'h40, 1'b0, 32'h77, 1'b0, r, e, t);
        send_req(32'h40, 1'b0, 32'h77);
        get_rsp("hold_rd", 32'h40, 1'b0, 32'h77, r, e, t, 2);
        ack_rsp("hold_rd");

        // Reset while the slave keeps the bridge in ACCESS; the write is lost.
        slv_hang = 1'b1;
        send_req(32'h30, 1'b1, 32'h11112222);
        @(negedge clk);
        chk("rst_mid.in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        slv_hang = 1'b0;
        chk("rst_mid.apb", {bus.PSEL, bus.PENABLE, bus.PWRITE, |bus.PADDR, |bus.PWDATA}, 5'b0);
        chk("rst_mid.rsp", {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, |bus.rsp_rdata}, 4'b0);
        chk("rst_mid.state", {bus.busy, bus.req_ready}, 2'b01);
        predict(32'h14, 1'b1, 32'h12345678, 1'b0, r, e, t);
        run_xfer("post_rst_wr", 32'h14, 1'b1, 32'h12345678, 0, 1'b0, r, e, t, 2);
        predict(32'h14, 1'b0, 32'h0, 1'b0, r, e, t);
        run_xfer("post_rst_rd", 32'h14, 1'b0, 32'h0, 0, 1'b0, r, e, t, 2);
        chk("post_rst_rd.value", r, 32'h12345678);

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            a  = 32'($urandom_range(0, 71)) << 2;
            w  = 1'($urandom);
            d  = $urandom;
            ws = $urandom_range(0, 4);
            h  = ($urandom_range(0, 9) == 0);
            predict(a, w, d, h, r, e, t);
            run_xfer($sformatf("rnd%0d", i), a, w, d, ws, h, r, e, t, h ? 2 + TMO : 2 + ws);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end, errors=%0d", errors);
        $fatal(1);
    end

endmodule
